// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode bundle for if_fetch_queue: redirects, debug loader, ID handshake.
interface if_fetch_queue_if #(
    parameter int NB_PC          = 32,
    parameter int NB_INSTRUCTION = 32,
    parameter int NB_MEM_WIDTH   = 8,
    parameter int QUEUE_DEPTH    = 4
);
    localparam int NB_CNT = $clog2(QUEUE_DEPTH) + 1;

    logic                      i_pc_enable;
    logic                      i_branch;
    logic [NB_PC-1:0]          i_branch_addr;
    logic                      i_j_jal;
    logic [NB_PC-1:0]          i_jump_addr;
    logic                      i_jr_jalr;
    logic [NB_PC-1:0]          i_jr_addr;
    logic                      i_write_enable;
    logic [NB_MEM_WIDTH-1:0]   i_write_data;
    logic                      i_id_ready;
    logic                      o_id_valid;
    logic [NB_INSTRUCTION-1:0] o_instruction;
    logic [NB_PC-1:0]          o_adder_result;
    logic [NB_CNT-1:0]         o_queue_count;
    logic                      o_halt;

    // fetch stage side
    modport slave (
        input  i_pc_enable, i_branch, i_branch_addr, i_j_jal, i_jump_addr,
               i_jr_jalr, i_jr_addr, i_write_enable, i_write_data, i_id_ready,
        output o_id_valid, o_instruction, o_adder_result, o_queue_count, o_halt
    );

    // control / decode / debug side
    modport master (
        output i_pc_enable, i_branch, i_branch_addr, i_j_jal, i_jump_addr,
               i_jr_jalr, i_jr_addr, i_write_enable, i_write_data, i_id_ready,
        input  o_id_valid, o_instruction, o_adder_result, o_queue_count, o_halt
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch with byte-loaded memory and a small {pc, instr} prefetch FIFO.
// Redirects flush the FIFO; fetching a HALT_WORD stops the PC until the next redirect.
module if_fetch_queue #(
    parameter int                      NB_PC          = 32,
    parameter int                      NB_INSTRUCTION = 32,
    parameter int                      NB_MEM_WIDTH   = 8,
    parameter int                      MEM_DEPTH      = 256,
    parameter int                      QUEUE_DEPTH    = 4,
    parameter logic [NB_INSTRUCTION-1:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    if_fetch_queue_if.slave  bus
);
    localparam int NB_ADDR = $clog2(MEM_DEPTH);
    localparam int NB_QPTR = $clog2(QUEUE_DEPTH);
    localparam int NB_CNT  = NB_QPTR + 1;
    localparam int BYTES   = NB_INSTRUCTION / NB_MEM_WIDTH;

    logic [NB_MEM_WIDTH-1:0]   r_mem   [MEM_DEPTH];
    logic [NB_PC-1:0]          r_q_pc  [QUEUE_DEPTH];
    logic [NB_INSTRUCTION-1:0] r_q_ins [QUEUE_DEPTH];
    logic [NB_ADDR-1:0]        r_wr_ptr;
    logic [NB_PC-1:0]          r_pc;
    logic                      r_halted;
    logic [NB_QPTR-1:0]        r_head;
    logic [NB_QPTR-1:0]        r_tail;
    logic [NB_CNT-1:0]         r_count;

    logic [NB_INSTRUCTION-1:0] w_word;
    logic [NB_PC-1:0]          w_target;
    logic                      w_redirect;
    logic                      w_valid;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_is_halt;

    // Big-endian word read; every byte address wraps within the memory.
    for (genvar b = 0; b < BYTES; b++) begin : g_rd
        logic [NB_ADDR-1:0] w_addr;
        assign w_addr = r_pc[NB_ADDR-1:0] + NB_ADDR'(b);
        assign w_word[(BYTES-1-b)*NB_MEM_WIDTH +: NB_MEM_WIDTH] = r_mem[w_addr];
    end

    // Redirect target select: jr/jalr beats j/jal beats branch.
    always_comb begin
        w_target = bus.i_branch_addr;
        if (bus.i_j_jal)   w_target = bus.i_jump_addr;
        if (bus.i_jr_jalr) w_target = bus.i_jr_addr;
    end

    assign w_redirect = bus.i_jr_jalr | bus.i_j_jal | bus.i_branch;
    assign w_valid    = (r_count != '0);
    assign w_full     = (r_count == NB_CNT'(QUEUE_DEPTH));
    assign w_pop      = w_valid & bus.i_id_ready;
    assign w_push     = bus.i_pc_enable & ~r_halted & ~w_redirect & (~w_full | w_pop);
    assign w_is_halt  = (w_word == HALT_WORD);

    // Debug loader byte write; memory is deliberately not cleared by reset.
    always_ff @(posedge i_clock) begin
        if (bus.i_write_enable) r_mem[r_wr_ptr] <= bus.i_write_data;
    end

    // FIFO payload; slots are only read while counted as occupied.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_q_pc[r_tail]  <= r_pc;
            r_q_ins[r_tail] <= w_word;
        end
    end

    // Loader pointer runs independently of fetch and wraps at MEM_DEPTH.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n)              r_wr_ptr <= '0;
        else if (bus.i_write_enable) r_wr_ptr <= r_wr_ptr + NB_ADDR'(1);
    end

    // PC, halt flag and FIFO bookkeeping; a redirect flushes and wins over push.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_pc     <= w_target & ~NB_PC'(3);
            r_halted <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + NB_QPTR'(1);
                if (w_is_halt) r_halted <= 1'b1;
                else           r_pc     <= r_pc + NB_PC'(4);
            end
            if (w_pop) r_head <= r_head + NB_QPTR'(1);
            if (w_push && !w_pop)      r_count <= r_count + NB_CNT'(1);
            else if (!w_push && w_pop) r_count <= r_count - NB_CNT'(1);
        end
    end

    // Head view is zeroed while empty so reset and flush present all-zero outputs.
    assign bus.o_id_valid     = w_valid;
    assign bus.o_instruction  = w_valid ? r_q_ins[r_head] : '0;
    assign bus.o_adder_result = w_valid ? r_q_pc[r_head] + NB_PC'(4) : '0;
    assign bus.o_queue_count  = r_count;
    assign bus.o_halt         = r_halted;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: queue-based reference model fed by the stimulus,
// monitor pops expected entries whenever ID accepts the head.
module tb_if_fetch_queue;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam int QD = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    if_fetch_queue_if #(.NB_PC(32), .NB_INSTRUCTION(32), .NB_MEM_WIDTH(8), .QUEUE_DEPTH(QD)) bus ();

    if_fetch_queue #(
        .NB_PC(32), .NB_INSTRUCTION(32), .NB_MEM_WIDTH(8),
        .MEM_DEPTH(256), .QUEUE_DEPTH(QD), .HALT_WORD(HALT)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [7:0]  m_mem [256];
    int          m_wr;
    logic [31:0] m_pc;
    bit          m_halted;
    ent_t        m_q[$];
    ent_t        exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w = {w[23:0], m_mem[(int'(pc[7:0]) + k) % 256]};
        return w;
    endfunction

    task automatic model_reset();
        m_pc = '0;
        m_halted = 0;
        m_wr = 0;
        m_q.delete();
        exp_q.delete();
    endtask

    // One clock of the architectural rules, evaluated just before the rising edge.
    task automatic model_step();
        bit          pop, push;
        logic [31:0] word, tgt;
        if (!rst_n) return;
        pop  = (m_q.size() > 0) && bus.i_id_ready;
        word = model_word(m_pc);
        if (bus.i_jr_jalr || bus.i_j_jal || bus.i_branch) begin
            tgt = bus.i_jr_jalr ? bus.i_jr_addr : (bus.i_j_jal ? bus.i_jump_addr : bus.i_branch_addr);
            m_pc = tgt & ~32'h3;
            m_halted = 0;
            m_q.delete();
            exp_q.delete();
        end else begin
            push = bus.i_pc_enable && !m_halted && (m_q.size() < QD || pop);
            if (pop) void'(m_q.pop_front());
            if (push) begin
                ent_t e;
                e.pc = m_pc;
                e.ins = word;
                m_q.push_back(e);
                exp_q.push_back(e);
                if (word == HALT) m_halted = 1;
                else              m_pc = m_pc + 32'd4;
            end
        end
        if (bus.i_write_enable) begin
            m_mem[m_wr] = bus.i_write_data;
            m_wr = (m_wr + 1) % 256;
        end
    endtask

    // Inputs are set at the falling edge by the caller; model advances at +4, edge at +5.
    task automatic cyc();
        #4 model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_pc_enable = 0; bus.i_id_ready = 0;
        bus.i_branch = 0; bus.i_j_jal = 0; bus.i_jr_jalr = 0;
        bus.i_branch_addr = '0; bus.i_jump_addr = '0; bus.i_jr_addr = '0;
        bus.i_write_enable = 0; bus.i_write_data = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_id_valid), 0);
        chk({tag, "_instr"}, bus.o_instruction, 0);
        chk({tag, "_adder"}, bus.o_adder_result, 0);
        chk({tag, "_count"}, 32'(bus.o_queue_count), 0);
        chk({tag, "_halt"}, 32'(bus.o_halt), 0);
    endtask

    // Monitor: compares status against the model and pops the scoreboard on each accept.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            chk("count", 32'(bus.o_queue_count), 32'(m_q.size()));
            chk("valid", 32'(bus.o_id_valid), 32'(exp_q.size() != 0));
            chk("halt", 32'(bus.o_halt), 32'(m_halted));
            compared++;
            assert (bus.o_queue_count <= QD) else begin
                mismatched++;
                $display("FAIL count_bound: got %0d expected <= %0d", bus.o_queue_count, QD);
            end
            if (bus.o_id_valid && bus.i_id_ready && exp_q.size() > 0) begin
                ent_t e;
                e = exp_q.pop_front();
                chk("instr", bus.o_instruction, e.ins);
                chk("adder", bus.o_adder_result, e.pc + 32'd4);
            end
        end
    end

    initial begin
        compared = 0;
        mismatched = 0;
        idle();
        model_reset();
        rst_n = 0;
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // load: words 1..16 at bytes 0..63, random elsewhere
        for (int i = 0; i < 256; i++) begin
            bus.i_write_enable = 1;
            bus.i_write_data = (i < 64) ? ((i % 4 == 3) ? 8'(i / 4 + 1) : 8'h00) : 8'($urandom);
            cyc();
        end
        idle();

        // streaming with ready high
        bus.i_pc_enable = 1; bus.i_id_ready = 1;
        cyc();
        chk("stream_first_adder", bus.o_adder_result, 32'd4);
        chk("stream_first_instr", bus.o_instruction, 32'd1);
        repeat (20) cyc();

        // back-pressure to full
        bus.i_branch = 1; bus.i_branch_addr = 32'h0; bus.i_id_ready = 0;
        cyc();
        bus.i_branch = 0;
        repeat (8) cyc();
        chk("full_count", 32'(bus.o_queue_count), 32'd4);
        chk("full_head_adder", bus.o_adder_result, 32'd4);
        bus.i_id_ready = 1;
        repeat (8) cyc();

        // simultaneous redirects: jr/jalr wins, low bits cleared
        bus.i_branch = 1; bus.i_branch_addr = 32'h40;
        bus.i_j_jal = 1; bus.i_jump_addr = 32'h80;
        bus.i_jr_jalr = 1; bus.i_jr_addr = 32'hC3;
        cyc();
        bus.i_branch = 0; bus.i_j_jal = 0; bus.i_jr_jalr = 0;
        chk("flush_valid", 32'(bus.o_id_valid), 0);
        cyc();
        chk("redir_adder", bus.o_adder_result, 32'hC4);
        repeat (4) cyc();

        // memory wrap at the top of the address space
        bus.i_jr_jalr = 1; bus.i_jr_addr = 32'hFC;
        cyc();
        bus.i_jr_jalr = 0;
        cyc();
        chk("wrap_adder", bus.o_adder_result, 32'h100);
        cyc();
        chk("wrap_next_adder", bus.o_adder_result, 32'h104);
        chk("wrap_next_instr", bus.o_instruction, 32'h1);
        repeat (3) cyc();

        // reload first 16 bytes, then HALT at 0x10
        bus.i_pc_enable = 0;
        for (int i = 0; i < 20; i++) begin
            bus.i_write_enable = 1;
            bus.i_write_data = (i >= 16) ? 8'hFF : ((i % 4 == 3) ? 8'(i / 4 + 1) : 8'h00);
            cyc();
        end
        bus.i_write_enable = 0;
        bus.i_pc_enable = 1;
        bus.i_branch = 1; bus.i_branch_addr = 32'h0;
        cyc();
        bus.i_branch = 0;
        repeat (10) cyc();
        chk("halt_set", 32'(bus.o_halt), 1);
        chk("halt_drained", 32'(bus.o_id_valid), 0);
        bus.i_branch = 1; bus.i_branch_addr = 32'h0;
        cyc();
        bus.i_branch = 0;
        chk("halt_cleared", 32'(bus.o_halt), 0);
        cyc();
        chk("resume_adder", bus.o_adder_result, 32'h4);
        repeat (3) cyc();

        // asynchronous reset with three entries queued
        bus.i_id_ready = 0;
        bus.i_branch = 1; bus.i_branch_addr = 32'h0;
        cyc();
        bus.i_branch = 0;
        repeat (3) cyc();
        chk("pre_reset_count", 32'(bus.o_queue_count), 32'd3);
        #1 rst_n = 0;
        model_reset();
        #1 chk_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        bus.i_id_ready = 1;
        cyc();
        chk("restart_adder", bus.o_adder_result, 32'h4);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bus.i_pc_enable    = ($urandom_range(0, 9) < 8);
            bus.i_id_ready     = ($urandom_range(0, 9) < 6);
            bus.i_branch       = ($urandom_range(0, 24) == 0);
            bus.i_j_jal        = ($urandom_range(0, 39) == 0);
            bus.i_jr_jalr      = ($urandom_range(0, 49) == 0);
            bus.i_branch_addr  = $urandom_range(0, 255);
            bus.i_jump_addr    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            bus.i_jr_addr      = $urandom;
            bus.i_write_enable = ($urandom_range(0, 9) == 0);
            bus.i_write_data   = 8'($urandom);
            cyc();
        end
        idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
